// File: rtl/conf_int_add_pipe_acc_if.sv
// Handshake and data bundle for conf_int_add_pipe_acc.
// The slave modport is the adder's view; the master modport is the view of whatever drives it.
interface conf_int_add_pipe_acc_if #(
  parameter int unsigned DATA_PATH_BITWIDTH = 24,
  parameter int unsigned ACC_BITWIDTH       = 32,
  parameter int unsigned CNT_BITWIDTH       = 8
);
  logic                          in_valid;
  logic                          in_ready;
  logic [DATA_PATH_BITWIDTH-1:0] a;
  logic [DATA_PATH_BITWIDTH-1:0] b;
  logic                          acc__sel;
  logic                          accum_en;
  logic                          acc_clr;
  logic                          out_valid;
  logic                          out_ready;
  logic [ACC_BITWIDTH-1:0]       d;
  logic                          sat_flag;
  logic [CNT_BITWIDTH-1:0]       beat_cnt;

  modport slave (
    input  in_valid, a, b, acc__sel, accum_en, acc_clr, out_ready,
    output in_ready, out_valid, d, sat_flag, beat_cnt
  );

  modport master (
    output in_valid, a, b, acc__sel, accum_en, acc_clr, out_ready,
    input  in_ready, out_valid, d, sat_flag, beat_cnt
  );
endinterface

// File: rtl/conf_int_add_pipe_acc.sv
// Two-stage configurable-precision adder with optional saturating accumulation.
// S1 adds the low half and registers the carry; S2 finishes the add and updates the accumulator.
module conf_int_add_pipe_acc #(
  parameter int unsigned DATA_PATH_BITWIDTH = 24,
  parameter int unsigned APX_DROP_BITS      = 8,
  parameter int unsigned ACC_BITWIDTH       = 32,
  parameter int unsigned CNT_BITWIDTH       = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  conf_int_add_pipe_acc_if.slave io
);
  localparam int unsigned DW = DATA_PATH_BITWIDTH;
  localparam int unsigned H  = DW / 2;
  localparam int unsigned AW = ACC_BITWIDTH;
  localparam int unsigned CW = CNT_BITWIDTH;

  // Built one bit wider so APX_DROP_BITS == DW yields an all-zero mask.
  localparam logic [DW:0]   ONE_SH   = (DW+1)'(1) << APX_DROP_BITS;
  localparam logic [DW-1:0] APX_MASK = ~DW'(ONE_SH - (DW+1)'(1));

  logic          en, accept;
  logic [DW-1:0] mask, am, bm;

  logic          s1_valid_q, s1_valid_d;
  logic [H:0]    lo_sum_q, lo_sum_d;
  logic [H-1:0]  a_hi_q, a_hi_d, b_hi_q, b_hi_d;
  logic          s1_accum_q, s1_accum_d, s1_clr_q, s1_clr_d;

  logic          out_valid_q, out_valid_d;
  logic [AW-1:0] d_q, d_d, acc_q, acc_d;
  logic          sat_q, sat_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic [H:0]    hi_sum;
  logic [DW:0]   sum;
  logic [AW-1:0] base;
  logic [AW:0]   t;

  always_comb begin
    en     = !out_valid_q || io.out_ready;
    accept = io.in_valid && en;
    mask   = io.acc__sel ? '1 : APX_MASK;
    am     = io.a & mask;
    bm     = io.b & mask;

    s1_valid_d  = s1_valid_q;
    lo_sum_d    = lo_sum_q;
    a_hi_d      = a_hi_q;
    b_hi_d      = b_hi_q;
    s1_accum_d  = s1_accum_q;
    s1_clr_d    = s1_clr_q;
    out_valid_d = out_valid_q;
    d_d         = d_q;
    acc_d       = acc_q;
    sat_d       = sat_q;
    cnt_d       = cnt_q;

    hi_sum = {1'b0, a_hi_q} + {1'b0, b_hi_q} + (H+1)'(lo_sum_q[H]);
    sum    = {hi_sum, lo_sum_q[H-1:0]};
    base   = s1_clr_q ? '0 : acc_q;
    t      = {1'b0, base} + (AW+1)'(sum);

    if (en) begin
      s1_valid_d  = accept;
      out_valid_d = s1_valid_q;
      if (accept) begin
        lo_sum_d   = {1'b0, am[H-1:0]} + {1'b0, bm[H-1:0]};
        a_hi_d     = am[DW-1:H];
        b_hi_d     = bm[DW-1:H];
        s1_accum_d = io.accum_en;
        s1_clr_d   = io.acc_clr;
      end
      // Accumulator state changes only here, so a stalled beat is never counted twice.
      if (s1_valid_q) begin
        if (!s1_accum_q) begin
          d_d = AW'(sum);
        end else begin
          sat_d = s1_clr_q ? 1'b0 : sat_q;
          if (t[AW]) begin
            acc_d = '1;
            sat_d = 1'b1;
          end else begin
            acc_d = t[AW-1:0];
          end
          d_d   = acc_d;
          cnt_d = s1_clr_q ? CW'(1) : ((cnt_q == '1) ? cnt_q : cnt_q + CW'(1));
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_valid_q  <= 1'b0;
      lo_sum_q    <= '0;
      a_hi_q      <= '0;
      b_hi_q      <= '0;
      s1_accum_q  <= 1'b0;
      s1_clr_q    <= 1'b0;
      out_valid_q <= 1'b0;
      d_q         <= '0;
      acc_q       <= '0;
      sat_q       <= 1'b0;
      cnt_q       <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      lo_sum_q    <= lo_sum_d;
      a_hi_q      <= a_hi_d;
      b_hi_q      <= b_hi_d;
      s1_accum_q  <= s1_accum_d;
      s1_clr_q    <= s1_clr_d;
      out_valid_q <= out_valid_d;
      d_q         <= d_d;
      acc_q       <= acc_d;
      sat_q       <= sat_d;
      cnt_q       <= cnt_d;
    end
  end

  assign io.in_ready  = en;
  assign io.out_valid = out_valid_q;
  assign io.d         = d_q;
  assign io.sat_flag  = sat_q;
  assign io.beat_cnt  = cnt_q;
endmodule

// File: tb/tb_conf_int_add_pipe_acc.sv
// Directed bench for conf_int_add_pipe_acc: a 32-bit accumulator instance for most
// scenarios plus a 26-bit instance to reach saturation quickly.
module tb_conf_int_add_pipe_acc;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  conf_int_add_pipe_acc_if #(.DATA_PATH_BITWIDTH(24), .ACC_BITWIDTH(32), .CNT_BITWIDTH(8)) m_if ();
  conf_int_add_pipe_acc_if #(.DATA_PATH_BITWIDTH(24), .ACC_BITWIDTH(26), .CNT_BITWIDTH(8)) s_if ();

  conf_int_add_pipe_acc #(
    .DATA_PATH_BITWIDTH(24), .APX_DROP_BITS(8), .ACC_BITWIDTH(32), .CNT_BITWIDTH(8)
  ) u_dut (.clk(clk), .rst(rst), .io(m_if.slave));

  conf_int_add_pipe_acc #(
    .DATA_PATH_BITWIDTH(24), .APX_DROP_BITS(8), .ACC_BITWIDTH(26), .CNT_BITWIDTH(8)
  ) u_dut26 (.clk(clk), .rst(rst), .io(s_if.slave));

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [23:0] aa, input logic [23:0] bb,
                       input logic sel, input logic ae, input logic clr);
    m_if.in_valid = v;  m_if.a = aa;  m_if.b = bb;
    m_if.acc__sel = sel; m_if.accum_en = ae; m_if.acc_clr = clr;
  endtask

  task automatic drive26(input logic v, input logic [23:0] aa, input logic [23:0] bb,
                         input logic clr);
    s_if.in_valid = v;  s_if.a = aa;  s_if.b = bb;
    s_if.acc__sel = 1'b1; s_if.accum_en = 1'b1; s_if.acc_clr = clr;
  endtask

  task automatic test_reset;
    rst = 1'b0;
    tick; tick;
    total++; if (m_if.out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid: got %b want 0", m_if.out_valid); end
    total++; if (m_if.d !== 32'h0) begin bad++; $display("FAIL rst_d: got %h want 0", m_if.d); end
    total++; if (m_if.beat_cnt !== 8'h0) begin bad++; $display("FAIL rst_cnt: got %0d want 0", m_if.beat_cnt); end
    total++; if (m_if.sat_flag !== 1'b0) begin bad++; $display("FAIL rst_sat: got %b want 0", m_if.sat_flag); end
    #3 rst = 1'b1;
    #1;
    total++; if (m_if.in_ready !== 1'b1) begin bad++; $display("FAIL rst_in_ready: got %b want 1", m_if.in_ready); end
    tick;
  endtask

  task automatic test_carry_split;
    drive(1, 24'h000FFF, 24'h000001, 1, 0, 0);
    tick;
    drive(0, 0, 0, 1, 0, 0);
    total++; if (m_if.out_valid !== 1'b0) begin bad++; $display("FAIL t1_early_valid: got %b want 0", m_if.out_valid); end
    tick;
    total++; if (m_if.out_valid !== 1'b1) begin bad++; $display("FAIL t1_valid: got %b want 1", m_if.out_valid); end
    total++; if (m_if.d !== 32'h00001000) begin bad++; $display("FAIL t1_d: got %h want 00001000", m_if.d); end
    tick;
    total++; if (m_if.out_valid !== 1'b0) begin bad++; $display("FAIL t1_pulse: got %b want 0", m_if.out_valid); end
  endtask

  task automatic test_modes;
    drive(1, 24'h0012FF, 24'h0001FF, 0, 0, 0);
    tick;
    drive(1, 24'h0012FF, 24'h0001FF, 1, 0, 0);
    tick;
    drive(0, 0, 0, 1, 0, 0);
    total++; if (m_if.out_valid !== 1'b1 || m_if.d !== 32'h00001300) begin
      bad++; $display("FAIL t2_apx: got v=%b d=%h want v=1 d=00001300", m_if.out_valid, m_if.d); end
    tick;
    total++; if (m_if.out_valid !== 1'b1 || m_if.d !== 32'h000014FE) begin
      bad++; $display("FAIL t2_acc: got v=%b d=%h want v=1 d=000014fe", m_if.out_valid, m_if.d); end
    tick;
  endtask

  task automatic test_accumulate;
    drive(1, 24'd5, 24'd5, 1, 1, 1);
    tick;
    drive(1, 24'd10, 24'd0, 1, 1, 0);
    tick;
    total++; if (m_if.d !== 32'd10 || m_if.beat_cnt !== 8'd1) begin
      bad++; $display("FAIL t3_b1: got d=%0d cnt=%0d want d=10 cnt=1", m_if.d, m_if.beat_cnt); end
    tick;
    drive(0, 0, 0, 1, 0, 0);
    total++; if (m_if.d !== 32'd20 || m_if.beat_cnt !== 8'd2) begin
      bad++; $display("FAIL t3_b2: got d=%0d cnt=%0d want d=20 cnt=2", m_if.d, m_if.beat_cnt); end
    tick;
    total++; if (m_if.d !== 32'd30 || m_if.beat_cnt !== 8'd3) begin
      bad++; $display("FAIL t3_b3: got d=%0d cnt=%0d want d=30 cnt=3", m_if.d, m_if.beat_cnt); end
    drive(1, 24'd1, 24'd1, 1, 1, 1);
    tick;
    drive(0, 0, 0, 1, 0, 0);
    tick;
    total++; if (m_if.d !== 32'd2 || m_if.beat_cnt !== 8'd1) begin
      bad++; $display("FAIL t3_clr: got d=%0d cnt=%0d want d=2 cnt=1", m_if.d, m_if.beat_cnt); end
    tick;
  endtask

  task automatic test_saturation;
    drive26(1, 24'hFFFFFF, 24'hFFFFFF, 1);
    tick;
    drive26(1, 24'hFFFFFF, 24'hFFFFFF, 0);
    tick;
    total++; if (s_if.d !== 26'h1FFFFFE || s_if.sat_flag !== 1'b0) begin
      bad++; $display("FAIL t4_b1: got d=%h sat=%b want 1fffffe sat=0", s_if.d, s_if.sat_flag); end
    tick;
    total++; if (s_if.d !== 26'h3FFFFFC || s_if.sat_flag !== 1'b0) begin
      bad++; $display("FAIL t4_b2: got d=%h sat=%b want 3fffffc sat=0", s_if.d, s_if.sat_flag); end
    drive26(1, 24'd1, 24'd1, 1);
    tick;
    drive26(0, 0, 0, 0);
    total++; if (s_if.d !== 26'h3FFFFFF || s_if.sat_flag !== 1'b1 || s_if.beat_cnt !== 8'd3) begin
      bad++; $display("FAIL t4_sat: got d=%h sat=%b cnt=%0d want 3ffffff sat=1 cnt=3", s_if.d, s_if.sat_flag, s_if.beat_cnt); end
    tick;
    total++; if (s_if.d !== 26'h2 || s_if.sat_flag !== 1'b0 || s_if.beat_cnt !== 8'd1) begin
      bad++; $display("FAIL t4_clr: got d=%h sat=%b cnt=%0d want 2 sat=0 cnt=1", s_if.d, s_if.sat_flag, s_if.beat_cnt); end
    tick;
  endtask

  task automatic test_back_to_back;
    m_if.out_ready = 1'b0;
    drive(1, 24'd1, 24'd0, 1, 1, 1);
    tick;
    drive(1, 24'd1, 24'd0, 1, 1, 0);
    tick;
    total++; if (m_if.in_ready !== 1'b0 || m_if.out_valid !== 1'b1 || m_if.d !== 32'd1) begin
      bad++; $display("FAIL t5_stall: got rdy=%b v=%b d=%0d want rdy=0 v=1 d=1", m_if.in_ready, m_if.out_valid, m_if.d); end
    tick; tick;
    total++; if (m_if.in_ready !== 1'b0 || m_if.d !== 32'd1 || m_if.beat_cnt !== 8'd1) begin
      bad++; $display("FAIL t5_hold: got rdy=%b d=%0d cnt=%0d want rdy=0 d=1 cnt=1", m_if.in_ready, m_if.d, m_if.beat_cnt); end
    m_if.out_ready = 1'b1;
    tick;
    total++; if (m_if.d !== 32'd2) begin bad++; $display("FAIL t5_d2: got %0d want 2", m_if.d); end
    tick;
    drive(0, 0, 0, 1, 0, 0);
    total++; if (m_if.d !== 32'd3) begin bad++; $display("FAIL t5_d3: got %0d want 3", m_if.d); end
    tick;
    total++; if (m_if.d !== 32'd4 || m_if.beat_cnt !== 8'd4 || m_if.out_valid !== 1'b1) begin
      bad++; $display("FAIL t5_d4: got d=%0d cnt=%0d v=%b want d=4 cnt=4 v=1", m_if.d, m_if.beat_cnt, m_if.out_valid); end
    tick;
    total++; if (m_if.out_valid !== 1'b0 || m_if.beat_cnt !== 8'd4) begin
      bad++; $display("FAIL t5_drain: got v=%b cnt=%0d want v=0 cnt=4", m_if.out_valid, m_if.beat_cnt); end
  endtask

  task automatic test_reset_inflight;
    drive(1, 24'd9, 24'd9, 1, 1, 1);
    tick;
    drive(1, 24'd9, 24'd9, 1, 1, 0);
    tick;
    drive(0, 0, 0, 1, 0, 0);
    rst = 1'b0;
    #1;
    total++; if (m_if.out_valid !== 1'b0 || m_if.d !== 32'd0 || m_if.beat_cnt !== 8'd0) begin
      bad++; $display("FAIL t6_async: got v=%b d=%0d cnt=%0d want 0 0 0", m_if.out_valid, m_if.d, m_if.beat_cnt); end
    #2 rst = 1'b1;
    tick;
    total++; if (m_if.out_valid !== 1'b0) begin bad++; $display("FAIL t6_flushed: got %b want 0", m_if.out_valid); end
    drive(1, 24'd3, 24'd4, 1, 1, 0);
    tick;
    drive(0, 0, 0, 1, 0, 0);
    tick;
    total++; if (m_if.out_valid !== 1'b1 || m_if.d !== 32'd7 || m_if.beat_cnt !== 8'd1) begin
      bad++; $display("FAIL t6_after: got v=%b d=%0d cnt=%0d want v=1 d=7 cnt=1", m_if.out_valid, m_if.d, m_if.beat_cnt); end
    tick;
  endtask

  initial begin
    drive(0, 0, 0, 1, 0, 0);
    drive26(0, 0, 0, 0);
    m_if.out_ready = 1'b1;
    s_if.out_ready = 1'b1;
    #1;
    test_reset;
    test_carry_split;
    test_modes;
    test_accumulate;
    test_saturation;
    test_back_to_back;
    test_reset_inflight;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1);
  end
endmodule

// File: doc/conf_int_add_pipe_acc.md
Name: conf_int_add_pipe_acc

Overview:
Pipelined, configurable-precision integer adder with optional running accumulation. Per beat, acc__sel selects accurate mode or approximate mode. Approximate mode zeroes the APX_DROP_BITS LSBs of both operands before the add.
The adder is split at DATA_PATH_BITWIDTH/2 across two register stages, with a valid/ready handshake at both ends. It replaces the flop-less adder wrapper in datapaths that need throughput, backpressure and accumulation.

Parameters:
DATA_PATH_BITWIDTH  24  operand width; must be even and >= 4
APX_DROP_BITS  8  LSBs zeroed in approximate mode; 0 <= value <= DATA_PATH_BITWIDTH
ACC_BITWIDTH  32  output/accumulator width; must be > DATA_PATH_BITWIDTH
CNT_BITWIDTH  8  accumulated-beat counter width

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous reset, active-low
in_valid  input  1  input beat valid
in_ready  output  1  block can accept a beat
a  input  DATA_PATH_BITWIDTH  operand A, unsigned
b  input  DATA_PATH_BITWIDTH  operand B, unsigned
acc__sel  input  1  1 = accurate, 0 = approximate; sampled per beat
accum_en  input  1  1 = add the sum into the accumulator, 0 = plain add
acc_clr  input  1  with accum_en: accumulator treated as 0 before this beat's add
out_valid  output  1  d is valid
out_ready  input  1  downstream accepts d
d  output  ACC_BITWIDTH  result
sat_flag  output  1  sticky: accumulator saturated
beat_cnt  output  CNT_BITWIDTH  accumulated beats since last clear

Behaviour:
- Reset (rst=0, async): S1 valid, out_valid, d, accumulator, sat_flag and beat_cnt are all 0. in_ready=1 once rst=1. Reset mid-operation discards in-flight beats and clears the accumulator.
- Pipeline enable: en = !out_valid || out_ready. in_ready = en, combinational. All stages advance only when en=1; otherwise every register holds.
- Accept: a beat is accepted when in_valid && in_ready.
- S1 operand masking: mask = acc__sel ? all-ones : ~((1<<APX_DROP_BITS)-1).
- S1 registers:
  - lo_sum = am[H-1:0] + bm[H-1:0], where H = DATA_PATH_BITWIDTH/2;
  - carry = bit H of lo_sum;
  - am[upper], bm[upper];
  - accum_en, acc_clr;
  - s1_valid = accepted.
- If en=1 and nothing is accepted, s1_valid becomes 0 (bubble).
- S2 sum: sum = {am_hi + bm_hi + carry, lo_sum[H-1:0]}, DATA_PATH_BITWIDTH+1 bits.
- S2, s1_valid with accum_en=0: d = zero-extended sum; accumulator untouched.
- S2, s1_valid with accum_en=1:
  - base = acc_clr ? 0 : acc;
  - t = base + sum, computed at ACC_BITWIDTH+1 bits;
  - if t overflows: acc = d = all-ones and sat_flag=1; else acc = d = t;
  - beat_cnt = (acc_clr ? 1 : beat_cnt+1), saturating at all-ones;
  - acc_clr also clears sat_flag before the overflow check of the same beat.
- out_valid <= s1_valid on en. d holds its value while out_valid && !out_ready.
- Latency: a beat accepted at clock edge N appears with out_valid=1 after edge N+1, i.e. 2 cycles, with no stall. Throughput is 1 beat/cycle.
- Accumulator side effects apply exactly once per beat, when the beat moves S1->output on en. A stall never double-counts.
- Beats leave in order. Mode bits travel with each beat, so mode changes between beats need no drain.

Test Plan:
1. acc__sel=1, accum_en=0, a=0x000FFF, b=0x000001 (carry crosses the 12-bit split) -> d=0x00001000 two cycles after accept; out_valid pulses for 1 cycle.
2. acc__sel=0, a=0x0012FF, b=0x0001FF -> d=0x00001300. The same operands with acc__sel=1 on the next beat -> d=0x000014FE. Outputs arrive back-to-back.
3. accum_en=1 beats: (5,5,clr=1), (10,0), (10,0) -> d=10,20,30 and beat_cnt=1,2,3. Then (1,1,clr=1) -> d=2, beat_cnt=1.
4. ACC_BITWIDTH=26, accum beats (0xFFFFFF,0xFFFFFF,clr=1) then repeat -> d=0x1FFFFFE, then 0x3FFFFFC. A third beat -> d=0x3FFFFFF, sat_flag=1. A clr beat (1,1) -> d=2, sat_flag=0.
5. Hold out_ready=0 while driving 4 accum beats of (1,0):
   - in_ready drops after 2 are accepted; d stays stable;
   - after release, d=1,2,3,4 in order;
   - beat_cnt ends at 4, with no double count.
6. Assert rst=0 while 2 beats are in flight -> out_valid=0, d=0, beat_cnt=0 immediately. After release, (3,4) -> d=7.
